// File: rtl/fwd_unit.sv
// Operand forwarding, load-use detection and E-stage operand registers.
// Optional statistics counters are compiled in when FWD_STATS_EN is defined.
module fwd_unit #(
  parameter int DATA_W = 32,
  parameter int ID_W   = 8,
  parameter int RNONE  = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        D_icode_i,
  input  logic [DATA_W-1:0] D_valP_i,
  input  logic [ID_W-1:0]   d_srcA_i,
  input  logic [ID_W-1:0]   d_srcB_i,
  input  logic [DATA_W-1:0] d_rvalA_i,
  input  logic [DATA_W-1:0] d_rvalB_i,
  input  logic [7:0]        E_icode_i,
  input  logic [ID_W-1:0]   E_dstM_i,
  input  logic [ID_W-1:0]   e_dstE_i,
  input  logic [DATA_W-1:0] e_valE_i,
  input  logic [ID_W-1:0]   M_dstM_i,
  input  logic [DATA_W-1:0] m_valM_i,
  input  logic [ID_W-1:0]   M_dstE_i,
  input  logic [DATA_W-1:0] M_valE_i,
  input  logic [ID_W-1:0]   W_dstM_i,
  input  logic [DATA_W-1:0] W_valM_i,
  input  logic [ID_W-1:0]   W_dstE_i,
  input  logic [DATA_W-1:0] W_valE_i,
  input  logic              E_stall_i,
  input  logic              E_bubble_i,
  output logic [DATA_W-1:0] d_valA_o,
  output logic [DATA_W-1:0] d_valB_o,
  output logic [DATA_W-1:0] E_valA_o,
  output logic [DATA_W-1:0] E_valB_o,
  output logic              E_valid_o,
  output logic              load_use_o
`ifdef FWD_STATS_EN
  ,
  output logic [31:0]       fwd_cnt_o,
  output logic [15:0]       luse_cnt_o
`endif
);

  localparam logic [7:0] IMRMOVL = 8'h5;
  localparam logic [7:0] IJXX    = 8'h7;
  localparam logic [7:0] ICALL   = 8'h8;
  localparam logic [7:0] IPOPL   = 8'hB;
  localparam logic [ID_W-1:0] RNONE_ID = ID_W'(RNONE);

  logic [DATA_W-1:0] e_valA_q, e_valA_d, e_valB_q, e_valB_d;
  logic              e_valid_q, e_valid_d;
  logic              a_fwd, b_fwd, use_valp;

  // Returns {hit, value}; a RNONE source never hits, so an RNONE destination can't either.
  function automatic logic [DATA_W:0] fwd_pick(
    input logic [ID_W-1:0]   src,
    input logic [DATA_W-1:0] rval,
    input logic [ID_W-1:0]   d0, input logic [DATA_W-1:0] v0,
    input logic [ID_W-1:0]   d1, input logic [DATA_W-1:0] v1,
    input logic [ID_W-1:0]   d2, input logic [DATA_W-1:0] v2,
    input logic [ID_W-1:0]   d3, input logic [DATA_W-1:0] v3,
    input logic [ID_W-1:0]   d4, input logic [DATA_W-1:0] v4);
    if (src == RNONE_ID) return {1'b0, rval};
    else if (d0 == src)  return {1'b1, v0};
    else if (d1 == src)  return {1'b1, v1};
    else if (d2 == src)  return {1'b1, v2};
    else if (d3 == src)  return {1'b1, v3};
    else if (d4 == src)  return {1'b1, v4};
    else                 return {1'b0, rval};
  endfunction

  logic [DATA_W:0] pick_a, pick_b;

  always_comb begin
    pick_a = fwd_pick(d_srcA_i, d_rvalA_i, e_dstE_i, e_valE_i, M_dstM_i, m_valM_i,
                      M_dstE_i, M_valE_i, W_dstM_i, W_valM_i, W_dstE_i, W_valE_i);
    pick_b = fwd_pick(d_srcB_i, d_rvalB_i, e_dstE_i, e_valE_i, M_dstM_i, m_valM_i,
                      M_dstE_i, M_valE_i, W_dstM_i, W_valM_i, W_dstE_i, W_valE_i);
    use_valp = (D_icode_i == ICALL) || (D_icode_i == IJXX);
    d_valA_o = use_valp ? D_valP_i : pick_a[DATA_W-1:0];
    a_fwd    = !use_valp && pick_a[DATA_W];
    d_valB_o = pick_b[DATA_W-1:0];
    b_fwd    = pick_b[DATA_W];
    load_use_o = ((E_icode_i == IMRMOVL) || (E_icode_i == IPOPL)) &&
                 (E_dstM_i != RNONE_ID) &&
                 ((E_dstM_i == d_srcA_i) || (E_dstM_i == d_srcB_i));
  end

  // Stall outranks both bubble sources; a stalled load-use bubble is simply dropped.
  always_comb begin
    e_valA_d  = e_valA_q;
    e_valB_d  = e_valB_q;
    e_valid_d = e_valid_q;
    if (!E_stall_i) begin
      if (E_bubble_i || load_use_o) begin
        e_valA_d  = '0;
        e_valB_d  = '0;
        e_valid_d = 1'b0;
      end else begin
        e_valA_d  = d_valA_o;
        e_valB_d  = d_valB_o;
        e_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      e_valA_q  <= '0;
      e_valB_q  <= '0;
      e_valid_q <= 1'b0;
    end else begin
      e_valA_q  <= e_valA_d;
      e_valB_q  <= e_valB_d;
      e_valid_q <= e_valid_d;
    end
  end

  assign E_valA_o  = e_valA_q;
  assign E_valB_o  = e_valB_q;
  assign E_valid_o = e_valid_q;

`ifdef FWD_STATS_EN
  logic [31:0] fwd_cnt_q, fwd_cnt_d;
  logic [15:0] luse_cnt_q, luse_cnt_d;
  logic        fwd_inc, luse_inc;

  always_comb begin
    fwd_inc    = !E_stall_i && !E_bubble_i && !load_use_o && (a_fwd || b_fwd);
    luse_inc   = load_use_o && !E_stall_i;
    fwd_cnt_d  = (fwd_inc && (fwd_cnt_q != '1)) ? fwd_cnt_q + 32'd1 : fwd_cnt_q;
    luse_cnt_d = (luse_inc && (luse_cnt_q != '1)) ? luse_cnt_q + 16'd1 : luse_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fwd_cnt_q  <= '0;
      luse_cnt_q <= '0;
    end else begin
      fwd_cnt_q  <= fwd_cnt_d;
      luse_cnt_q <= luse_cnt_d;
    end
  end

  assign fwd_cnt_o  = fwd_cnt_q;
  assign luse_cnt_o = luse_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_unit.sv
// Self-checking bench for fwd_unit: hand vector table, corner sequences, and
// randomized traffic against a priority-list reference model.
module tb_fwd_unit;
  localparam int RN = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  D_icode, E_icode;
  logic [31:0] D_valP, d_rvalA, d_rvalB;
  logic [7:0]  d_srcA, d_srcB, E_dstM, e_dstE, M_dstM, M_dstE, W_dstM, W_dstE;
  logic [31:0] e_valE, m_valM, M_valE, W_valM, W_valE;
  logic        E_stall, E_bubble;
  logic [31:0] d_valA, d_valB, E_valA, E_valB;
  logic        E_valid, load_use;
`ifdef FWD_STATS_EN
  logic [31:0] fwd_cnt;
  logic [15:0] luse_cnt;
  int unsigned m_fwd, m_luse;
`endif

  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] m_ea, m_eb;
  logic        m_ev;

  always #5 clk = ~clk;

  fwd_unit #(.DATA_W(32), .ID_W(8), .RNONE(RN)) dut (
    .clk(clk), .rst(rst),
    .D_icode_i(D_icode), .D_valP_i(D_valP),
    .d_srcA_i(d_srcA), .d_srcB_i(d_srcB), .d_rvalA_i(d_rvalA), .d_rvalB_i(d_rvalB),
    .E_icode_i(E_icode), .E_dstM_i(E_dstM),
    .e_dstE_i(e_dstE), .e_valE_i(e_valE), .M_dstM_i(M_dstM), .m_valM_i(m_valM),
    .M_dstE_i(M_dstE), .M_valE_i(M_valE), .W_dstM_i(W_dstM), .W_valM_i(W_valM),
    .W_dstE_i(W_dstE), .W_valE_i(W_valE),
    .E_stall_i(E_stall), .E_bubble_i(E_bubble),
    .d_valA_o(d_valA), .d_valB_o(d_valB), .E_valA_o(E_valA), .E_valB_o(E_valB),
    .E_valid_o(E_valid), .load_use_o(load_use)
`ifdef FWD_STATS_EN
    , .fwd_cnt_o(fwd_cnt), .luse_cnt_o(luse_cnt)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference: walk the sources in priority order, first live match wins.
  function automatic logic [32:0] ref_fwd(input logic [7:0] src, input logic [31:0] rval,
                                          input bit chan_a);
    logic [7:0]  ids[5];
    logic [31:0] vals[5];
    ids  = '{e_dstE, M_dstM, M_dstE, W_dstM, W_dstE};
    vals = '{e_valE, m_valM, M_valE, W_valM, W_valE};
    if (chan_a && (D_icode == 8'h7 || D_icode == 8'h8)) return {1'b0, D_valP};
    if (src == 8'(RN)) return {1'b0, rval};
    for (int k = 0; k < 5; k++)
      if (ids[k] != 8'(RN) && ids[k] == src) return {1'b1, vals[k]};
    return {1'b0, rval};
  endfunction

  function automatic logic ref_lu();
    return ((E_icode == 8'h5) || (E_icode == 8'hB)) && (E_dstM != 8'(RN)) &&
           ((E_dstM == d_srcA) || (E_dstM == d_srcB));
  endfunction

  // Check combinational outputs, advance one edge, check registered outputs.
  task automatic tick(input string tag);
    logic [32:0] ra, rb;
    logic        lu;
    #1;
    ra = ref_fwd(d_srcA, d_rvalA, 1'b1);
    rb = ref_fwd(d_srcB, d_rvalB, 1'b0);
    lu = ref_lu();
    chk({tag, " d_valA"}, d_valA, ra[31:0]);
    chk({tag, " d_valB"}, d_valB, rb[31:0]);
    chk({tag, " load_use"}, 32'(load_use), 32'(lu));
    if (!rst) begin
      m_ea = 0; m_eb = 0; m_ev = 0;
    end else if (!E_stall) begin
      if (E_bubble || lu) begin
        m_ea = 0; m_eb = 0; m_ev = 0;
      end else begin
        m_ea = ra[31:0]; m_eb = rb[31:0]; m_ev = 1;
      end
    end
`ifdef FWD_STATS_EN
    if (!rst) begin
      m_fwd = 0; m_luse = 0;
    end else begin
      if (!E_stall && !E_bubble && !lu && (ra[32] || rb[32]) && m_fwd != 32'hFFFF_FFFF) m_fwd++;
      if (lu && !E_stall && m_luse != 16'hFFFF) m_luse++;
    end
`endif
    @(posedge clk);
    #1;
    chk({tag, " E_valA"}, E_valA, m_ea);
    chk({tag, " E_valB"}, E_valB, m_eb);
    chk({tag, " E_valid"}, 32'(E_valid), 32'(m_ev));
`ifdef FWD_STATS_EN
    chk({tag, " fwd_cnt"}, fwd_cnt, m_fwd);
    chk({tag, " luse_cnt"}, 32'(luse_cnt), m_luse);
`endif
  endtask

  task automatic quiet();
    D_icode = 8'h1; E_icode = 8'h1; E_dstM = 8'(RN);
    e_dstE = 8'(RN); M_dstM = 8'(RN); M_dstE = 8'(RN); W_dstM = 8'(RN); W_dstE = 8'(RN);
    D_valP = 32'h40; d_rvalA = 32'h99; d_rvalB = 32'hB0;
    e_valE = 32'h11; M_valE = 32'h22; m_valM = 32'h33; W_valM = 32'h44; W_valE = 32'h55;
    E_stall = 0; E_bubble = 0;
  endtask

  typedef struct packed {
    logic [7:0]  dic, sa, sb, ee, mm, me, wm, we, eic, edm;
    logic [31:0] xa, xb;
    logic        xl;
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{8'h1, 8'd3, 8'd4, 8'd3, 8'd15, 8'd3, 8'd15, 8'd15, 8'h1, 8'd15, 32'h11, 32'hB0, 1'b0};
    tbl[1]  = '{8'h8, 8'd2, 8'd2, 8'd2, 8'd15, 8'd15, 8'd15, 8'd15, 8'h1, 8'd15, 32'h40, 32'h11, 1'b0};
    tbl[2]  = '{8'h1, 8'd15, 8'd15, 8'd15, 8'd15, 8'd15, 8'd15, 8'd15, 8'h1, 8'd15, 32'h99, 32'hB0, 1'b0};
    tbl[3]  = '{8'h1, 8'd5, 8'd5, 8'd15, 8'd5, 8'd5, 8'd5, 8'd15, 8'h1, 8'd15, 32'h33, 32'h33, 1'b0};
    tbl[4]  = '{8'h1, 8'd6, 8'd7, 8'd15, 8'd15, 8'd6, 8'd6, 8'd7, 8'h1, 8'd15, 32'h22, 32'h55, 1'b0};
    tbl[5]  = '{8'h1, 8'd1, 8'd2, 8'd15, 8'd15, 8'd15, 8'd1, 8'd1, 8'h1, 8'd15, 32'h44, 32'hB0, 1'b0};
    tbl[6]  = '{8'h7, 8'd15, 8'd3, 8'd3, 8'd15, 8'd15, 8'd15, 8'd15, 8'h1, 8'd15, 32'h40, 32'h11, 1'b0};
    tbl[7]  = '{8'h1, 8'd0, 8'd6, 8'd15, 8'd15, 8'd15, 8'd15, 8'd15, 8'h5, 8'd6, 32'h99, 32'hB0, 1'b1};
    tbl[8]  = '{8'h1, 8'd2, 8'd0, 8'd15, 8'd15, 8'd15, 8'd15, 8'd15, 8'hB, 8'd2, 32'h99, 32'hB0, 1'b1};
    tbl[9]  = '{8'h1, 8'd15, 8'd0, 8'd15, 8'd15, 8'd15, 8'd15, 8'd15, 8'h5, 8'd15, 32'h99, 32'hB0, 1'b0};
    tbl[10] = '{8'h1, 8'd3, 8'd0, 8'd15, 8'd15, 8'd15, 8'd15, 8'd15, 8'h6, 8'd3, 32'h99, 32'hB0, 1'b0};
    tbl[11] = '{8'h1, 8'd9, 8'd0, 8'd15, 8'd15, 8'd15, 8'd15, 8'd9, 8'h1, 8'd15, 32'h55, 32'hB0, 1'b0};

    quiet();
    d_srcA = 8'd3; d_srcB = 8'd4; e_dstE = 8'd3;
    rst = 0;
    m_ea = 'x; m_eb = 'x; m_ev = 'x;
`ifdef FWD_STATS_EN
    m_fwd = 0; m_luse = 0;
`endif
    @(posedge clk); #1;
    tick("reset");
    chk("reset comb d_valA", d_valA, 32'h11);
    rst = 1;

    foreach (tbl[i]) begin
      quiet();
      D_icode = tbl[i].dic; d_srcA = tbl[i].sa; d_srcB = tbl[i].sb;
      e_dstE = tbl[i].ee; M_dstM = tbl[i].mm; M_dstE = tbl[i].me;
      W_dstM = tbl[i].wm; W_dstE = tbl[i].we; E_icode = tbl[i].eic; E_dstM = tbl[i].edm;
      #1;
      chk($sformatf("tbl%0d dA", i), d_valA, tbl[i].xa);
      chk($sformatf("tbl%0d dB", i), d_valB, tbl[i].xb);
      chk($sformatf("tbl%0d lu", i), 32'(load_use), 32'(tbl[i].xl));
      tick($sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d E_valA", i), E_valA, tbl[i].xl ? 32'h0 : tbl[i].xa);
      chk($sformatf("tbl%0d E_valid", i), 32'(E_valid), tbl[i].xl ? 32'd0 : 32'd1);
    end

    // Stalled load-use holds a live instruction, then the unstalled hazard bubbles.
    quiet(); d_srcA = 8'd1; d_srcB = 8'd2; W_dstE = 8'd2;
    tick("seq load");
    E_icode = 8'h5; E_dstM = 8'd2; E_stall = 1;
    tick("seq stall+lu");
    chk("seq stall hold valid", 32'(E_valid), 32'd1);
    chk("seq stall hold valB", E_valB, 32'h55);
    E_stall = 0;
    tick("seq lu bubble");
    chk("seq lu bubble valid", 32'(E_valid), 32'd0);

    quiet(); d_srcA = 8'd1; d_srcB = 8'd2;
    tick("seq load2");
    E_bubble = 1;
    tick("seq ext bubble");
    chk("seq ext bubble valid", 32'(E_valid), 32'd0);

    // Reset outranks stall.
    quiet(); d_srcA = 8'd1; d_srcB = 8'd2;
    tick("seq load3");
    E_stall = 1; rst = 0;
    tick("seq rst+stall");
    chk("seq rst valid", 32'(E_valid), 32'd0);
    chk("seq rst valA", E_valA, 32'd0);
    rst = 1;

    for (int n = 0; n < 400; n++) begin
      D_icode = 8'($urandom_range(0, 11)); E_icode = 8'($urandom_range(0, 11));
      d_srcA = 8'($urandom_range(0, 15)); d_srcB = 8'($urandom_range(0, 15));
      E_dstM = 8'($urandom_range(0, 15)); e_dstE = 8'($urandom_range(0, 15));
      M_dstM = 8'($urandom_range(0, 15)); M_dstE = 8'($urandom_range(0, 15));
      W_dstM = 8'($urandom_range(0, 15)); W_dstE = 8'($urandom_range(0, 15));
      D_valP = $urandom; d_rvalA = $urandom; d_rvalB = $urandom;
      e_valE = $urandom; m_valM = $urandom; M_valE = $urandom; W_valM = $urandom; W_valE = $urandom;
      E_stall = ($urandom_range(0, 3) == 0); E_bubble = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 19) != 0);
      tick($sformatf("rnd%0d", n));
    end
    rst = 1;

`ifdef FWD_STATS_EN
    quiet(); rst = 0;
    @(posedge clk); #1;
    rst = 1; d_srcB = 8'd6; E_icode = 8'h5; E_dstM = 8'd6;
    for (int n = 0; n < 65539; n++) @(posedge clk);
    #1;
    chk("luse_cnt saturate", 32'(luse_cnt), 32'hFFFF);
    quiet(); rst = 0;
    @(posedge clk); #1;
    rst = 1; d_srcA = 8'd4; e_dstE = 8'd4;
    for (int n = 0; n < 5; n++) @(posedge clk);
    #1;
    chk("fwd_cnt five", fwd_cnt, 32'd5);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/fwd_unit.md
FWD_UNIT -- requirements
Module: fwd_unit

Interface
REQ-001 Parameter DATA_W, default 32, data word width.
REQ-002 Parameter ID_W, default 8, register-ID width.
REQ-003 Parameter RNONE, default 15, "no register" ID; never matches any source.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-low reset.
REQ-006 D_icode_i  in  8  decode-stage icode.
REQ-007 D_valP_i  in  DATA_W  decode-stage next PC.
REQ-008 d_srcA_i, d_srcB_i  in  ID_W  decode source IDs.
REQ-009 d_rvalA_i, d_rvalB_i  in  DATA_W  register-file read values.
REQ-010 E_icode_i  in  8  execute-stage icode.
REQ-011 E_dstM_i  in  ID_W  execute-stage memory destination.
REQ-012 e_dstE_i/e_valE_i, M_dstM_i/m_valM_i, M_dstE_i/M_valE_i, W_dstM_i/W_valM_i, W_dstE_i/W_valE_i  in  ID_W/DATA_W  forwarding sources.
REQ-013 E_stall_i  in  1  hold E registers.
REQ-014 E_bubble_i  in  1  external bubble request for E.
REQ-015 d_valA_o, d_valB_o  out  DATA_W  combinational forwarded operands.
REQ-016 E_valA_o, E_valB_o  out  DATA_W  registered operands into execute.
REQ-017 E_valid_o  out  1  E registers hold a real instruction.
REQ-018 load_use_o  out  1  combinational load-use hazard flag.

Function
REQ-019 Per channel (A, B), match priority SHALL be e_dstE > M_dstM > M_dstE > W_dstM > W_dstE > register-file value.
REQ-020 A source equal to RNONE SHALL select the register-file value; a destination equal to RNONE SHALL never match.
REQ-021 Channel A only: D_icode_i = ICALL or IJXX SHALL select D_valP_i and override all forwarding; channel B is unaffected.
REQ-022 load_use_o SHALL be 1 when E_icode_i is IMRMOVL or IPOPL, E_dstM_i != RNONE, and E_dstM_i equals d_srcA_i or d_srcB_i; otherwise 0.
REQ-023 Per edge, E-register update priority: E_stall_i=1 -> hold all; else E_bubble_i=1 or load_use_o=1 -> E_valA_o=0, E_valB_o=0, E_valid_o=0; else load d_valA_o, d_valB_o, E_valid_o=1.
REQ-024 E_stall_i together with load_use_o SHALL hold (stall wins); the bubble is not deferred.
REQ-025 Latency: d_val*_o zero cycles; E_val*_o one cycle after the capturing edge.
REQ-026 All datapaths SHALL be DATA_W wide, with no truncation or extension.

Reset
REQ-027 When rst=0 at a rising edge: E_valA_o=0, E_valB_o=0, E_valid_o=0, and statistics counters cleared; reset overrides stall and bubble.
REQ-028 Combinational outputs SHALL follow their inputs during reset.

Configuration
REQ-029 Macro FWD_STATS_EN defined: add outputs fwd_cnt_o (32 bits) and luse_cnt_o (16 bits).
- fwd_cnt_o counts edges where an unstalled, non-bubbled load occurred with at least one channel forwarded (not from the register file, not valP).
- luse_cnt_o counts edges with load_use_o=1 and E_stall_i=0.
- Both counters saturate at all-ones.
REQ-030 FWD_STATS_EN undefined: those ports and counters SHALL be absent; all other behaviour is identical.

Verification
REQ-031 srcA=3, e_dstE=3/valE=0x11, M_dstE=3/valE=0x22, rvalA=0x99 -> d_valA_o=0x11; next edge E_valA_o=0x11, E_valid_o=1.
REQ-032 D_icode=ICALL, valP=0x40, srcA=2=e_dstE, srcB=2 -> d_valA_o=0x40, d_valB_o=e_valE_i.
REQ-033 srcA=RNONE, W_dstE=RNONE, rvalA=0x5 -> d_valA_o=0x5.
REQ-034 E_icode=IMRMOVL, E_dstM=6, srcB=6 -> load_use_o=1; next edge E_valid_o=0, E_valA/B_o=0; with E_stall_i=1 instead -> E outputs held.
REQ-035 rst=0 mid-stream with E_valid_o=1 and E_stall_i=1 -> after the edge all registered outputs are 0.
REQ-036 FWD_STATS_EN: force 2^16+3 load-use cycles -> luse_cnt_o=0xFFFF; 5 forwarded loads -> fwd_cnt_o=5.
